bubble_sort_controller: RTL and testbench
=========================================

BUBBLE_SORT_CONTROLLER -- requirements
Module: bubble_sort_controller

Interface
REQ-001 SHALL take parameter DATA_W, 16, element width in bits.
REQ-002 SHALL take parameter ADDR_W, 10, index and address width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to sort mem[0..n-1].
REQ-006 SHALL have port n  input  ADDR_W  element count, sampled only on an accepted start.
REQ-007 SHALL have port i, j  input  ADDR_W each  loop indices returned from the datapath registers.
REQ-008 SHALL have port A, B  input  DATA_W each  operands returned from the datapath registers.
REQ-009 SHALL have port mux_sel_i, mux_sel_j  output  2 each  index next-value select: 0 = zero, 1 = alu_result.
REQ-010 SHALL have port mux_sel_k  output  1  k select; held 0.
REQ-011 SHALL have port load_i, load_j, load_k, load_A, load_B  output  1 each  datapath register enables.
REQ-012 SHALL have port alu_op  output  2  0 = i+1, 1 = j+1; other codes unused.
REQ-013 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-014 SHALL have port mem_re  output  1  read strobe.
REQ-015 SHALL have port mem_we  output  1  write strobe.
REQ-016 SHALL have port mem_wdata  output  DATA_W  write data.
REQ-017 SHALL have port busy  output  1  high from an accepted start until done.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement a Moore FSM with states IDLE, INIT, CHK_I, RD_A, LD_A, RD_B, LD_B, CMP, WR_J, WR_J1, NEXT_J, CHK_J, NEXT_I, DONE; all outputs default to 0 in every state except where listed below.
REQ-020 IDLE: on start=1, latch n into n_reg and go to INIT; start while busy=1 SHALL be ignored.
REQ-021 INIT: load_i=1, load_j=1, mux_sel_i=0, mux_sel_j=0; go to CHK_I.
REQ-022 CHK_I: if n_reg<2 or i>=n_reg-1, go to DONE; else go to RD_A.
REQ-023 RD_A: mem_re=1, mem_addr=j; go to LD_A.
REQ-024 Memory read latency SHALL be exactly 1 cycle; in LD_A, load_A=1; go to RD_B.
REQ-025 RD_B: mem_re=1, mem_addr=j+1 (ADDR_W bits); go to LD_B.
REQ-026 LD_B: load_B=1; go to CMP.
REQ-027 CMP: if A>B (unsigned), go to WR_J; else go to NEXT_J.
REQ-028 WR_J: mem_we=1, mem_addr=j, mem_wdata=B; go to WR_J1.
REQ-029 WR_J1: mem_we=1, mem_addr=j+1, mem_wdata=A; go to NEXT_J.
REQ-030 NEXT_J: alu_op=1, mux_sel_j=1, load_j=1; go to CHK_J.
REQ-031 CHK_J: if j >= n_reg-1-i, go to NEXT_I; else go to RD_A.
REQ-032 All bound arithmetic SHALL be computed in ADDR_W+1 bits so that n_reg-1-i never wraps.
REQ-033 NEXT_I: alu_op=0, mux_sel_i=1, load_i=1, mux_sel_j=0, load_j=1; go to CHK_I.
REQ-034 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 mem_re and mem_we SHALL never both be 1.
REQ-037 load_k and mux_sel_k SHALL always be 0.
REQ-038 Cycle budget per inner iteration SHALL be 7 cycles without a swap and 9 cycles with a swap.

Reset
REQ-039 rst=1 at any clock edge, including mid-sort, SHALL force state=IDLE and n_reg=0, with all outputs 0 on the following cycle.
REQ-040 A write in progress when rst is applied SHALL be abandoned; memory contents are then undefined for that element pair only.

Verification
REQ-041 n=2, mem={5,3}, start -> mem={3,5}; exactly one WR_J/WR_J1 pair; done 1 cycle; busy low afterward.
REQ-042 n=4, mem={4,3,2,1} -> mem={1,2,3,4}; 6 swaps; no address >=4 driven.
REQ-043 n=1 and n=0 -> no mem_re/mem_we; done asserted 3 cycles after start (IDLE->INIT->CHK_I->DONE).
REQ-044 n=3, mem={1,2,3} (already sorted) -> zero mem_we pulses; 3 compares; contents unchanged.
REQ-045 rst=1 during WR_J of n=4 sort -> next cycle busy=0, all strobes 0; a new start then sorts {9,0xFFFF,0,7} -> {0,7,9,0xFFFF} (unsigned).
REQ-046 start pulsed again while busy -> ignored; n_reg is unchanged; exactly one done pulse.

Source files
------------

// File: rtl/bubble_sort_controller_if.sv
// Controller <-> datapath/memory signal bundle for the bubble-sort controller.
// master = controller side, slave = datapath/memory side.
interface bubble_sort_controller_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [1:0]        mux_sel_i;
    logic [1:0]        mux_sel_j;
    logic              mux_sel_k;
    logic              load_i;
    logic              load_j;
    logic              load_k;
    logic              load_A;
    logic              load_B;
    logic [1:0]        alu_op;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;

    modport master (
        input  start, n, i, j, A, B,
        output mux_sel_i, mux_sel_j, mux_sel_k,
        output load_i, load_j, load_k, load_A, load_B,
        output alu_op, mem_addr, mem_re, mem_we, mem_wdata, busy, done
    );

    modport slave (
        output start, n, i, j, A, B,
        input  mux_sel_i, mux_sel_j, mux_sel_k,
        input  load_i, load_j, load_k, load_A, load_B,
        input  alu_op, mem_addr, mem_re, mem_we, mem_wdata, busy, done
    );
endinterface

// File: rtl/bubble_sort_controller.sv
// Moore FSM sequencing an external datapath (i/j/A/B registers, ALU, memory)
// through an in-place ascending bubble sort of mem[0..n-1].
//
// state  | meaning
// IDLE   | wait for start, latch n     | INIT   | clear i and j
// CHK_I  | outer-loop bound test       | RD_A   | read mem[j]
// LD_A   | capture A                   | RD_B   | read mem[j+1]
// LD_B   | capture B                   | CMP    | A > B ?
// WR_J   | mem[j] <= B                 | WR_J1  | mem[j+1] <= A
// NEXT_J | j <= j+1                    | CHK_J  | inner-loop bound test
// NEXT_I | i <= i+1, j <= 0            | DONE   | one-cycle completion pulse
module bubble_sort_controller #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input logic                       clk,
    input logic                       rst,
    bubble_sort_controller_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE, INIT, CHK_I, RD_A, LD_A, RD_B, LD_B, CMP,
        WR_J, WR_J1, NEXT_J, CHK_J, NEXT_I, DONE
    } state_t;

    localparam logic [ADDR_W:0]   ONE_EXT = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] n_reg;
    logic [ADDR_W:0]   n_ext, i_ext, j_ext;
    logic [ADDR_W:0]   i_bound, j_bound;
    logic [ADDR_W-1:0] j_plus1;

    // One extra bit keeps n_reg-1-i from wrapping whenever the bound is consulted.
    assign n_ext   = {1'b0, n_reg};
    assign i_ext   = {1'b0, bus.i};
    assign j_ext   = {1'b0, bus.j};
    assign i_bound = n_ext - ONE_EXT;
    assign j_bound = n_ext - ONE_EXT - i_ext;
    assign j_plus1 = bus.j + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            n_reg <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                n_reg <= bus.n;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.mux_sel_i = 2'd0;
        bus.mux_sel_j = 2'd0;
        bus.mux_sel_k = 1'b0;
        bus.load_i    = 1'b0;
        bus.load_j    = 1'b0;
        bus.load_k    = 1'b0;
        bus.load_A    = 1'b0;
        bus.load_B    = 1'b0;
        bus.alu_op    = 2'd0;
        bus.mem_addr  = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;

        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = INIT;
            end
            INIT: begin
                bus.load_i = 1'b1;
                bus.load_j = 1'b1;
                state_nxt  = CHK_I;
            end
            CHK_I: begin
                if (n_reg < TWO || i_ext >= i_bound) state_nxt = DONE;
                else                                 state_nxt = RD_A;
            end
            RD_A: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = bus.j;
                state_nxt    = LD_A;
            end
            LD_A: begin
                bus.load_A = 1'b1;
                state_nxt  = RD_B;
            end
            RD_B: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = j_plus1;
                state_nxt    = LD_B;
            end
            LD_B: begin
                bus.load_B = 1'b1;
                state_nxt  = CMP;
            end
            CMP: begin
                if (bus.A > bus.B) state_nxt = WR_J;
                else               state_nxt = NEXT_J;
            end
            WR_J: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = bus.j;
                bus.mem_wdata = bus.B;
                state_nxt     = WR_J1;
            end
            WR_J1: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = j_plus1;
                bus.mem_wdata = bus.A;
                state_nxt     = NEXT_J;
            end
            NEXT_J: begin
                bus.alu_op    = 2'd1;
                bus.mux_sel_j = 2'd1;
                bus.load_j    = 1'b1;
                state_nxt     = CHK_J;
            end
            CHK_J: begin
                if (j_ext >= j_bound) state_nxt = NEXT_I;
                else                  state_nxt = RD_A;
            end
            NEXT_I: begin
                bus.alu_op    = 2'd0;
                bus.mux_sel_i = 2'd1;
                bus.load_i    = 1'b1;
                bus.mux_sel_j = 2'd0;
                bus.load_j    = 1'b1;
                state_nxt     = CHK_I;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bubble_sort_controller.sv
// Bench for bubble_sort_controller: models the datapath and a 1-cycle-latency
// memory, then checks sort results, strobe counts and cycle totals.
module tb_bubble_sort_controller;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int MEM_D  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bubble_sort_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    bubble_sort_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // datapath + memory model
    logic [ADDR_W-1:0] dp_i, dp_j, alu;
    logic [DATA_W-1:0] dp_a, dp_b, rdata;
    logic [DATA_W-1:0] mem [MEM_D];
    logic              tb_wr;
    logic [3:0]        tb_waddr;
    logic [DATA_W-1:0] tb_wdata;

    assign bus.i = dp_i;
    assign bus.j = dp_j;
    assign bus.A = dp_a;
    assign bus.B = dp_b;
    assign alu   = (bus.alu_op == 2'd1) ? dp_j + ADDR_W'(1) : dp_i + ADDR_W'(1);

    always @(posedge clk) begin
        if (tb_wr) mem[tb_waddr] <= tb_wdata;
        else if (bus.mem_we && bus.mem_addr < ADDR_W'(MEM_D)) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
        if (bus.mem_re) rdata <= (bus.mem_addr < ADDR_W'(MEM_D)) ? mem[bus.mem_addr[3:0]] : '0;
        if (bus.load_A) dp_a <= rdata;
        if (bus.load_B) dp_b <= rdata;
        if (bus.load_i) dp_i <= (bus.mux_sel_i == 2'd1) ? alu : '0;
        if (bus.load_j) dp_j <= (bus.mux_sel_j == 2'd1) ? alu : '0;
    end

    // strobe monitor, sampled mid-cycle
    int re_cnt = 0, we_cnt = 0, both_cnt = 0, addr_viol = 0, k_viol = 0, done_cnt = 0;
    int lim = MEM_D;
    always @(negedge clk) begin
        if (bus.mem_re) re_cnt++;
        if (bus.mem_we) we_cnt++;
        if (bus.mem_re && bus.mem_we) both_cnt++;
        if ((bus.mem_re || bus.mem_we) && int'(bus.mem_addr) >= lim) addr_viol++;
        if (bus.load_k || bus.mux_sel_k) k_viol++;
        if (bus.done) done_cnt++;
    end

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] vals [MEM_D];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.mux_sel_i, bus.mux_sel_j, bus.mux_sel_k, bus.load_i, bus.load_j,
                    bus.load_k, bus.load_A, bus.load_B, bus.alu_op, bus.mem_addr,
                    bus.mem_re, bus.mem_we, bus.mem_wdata, bus.busy, bus.done});
    endfunction

    task automatic load_mem();
        for (int p = 0; p < MEM_D; p++) begin
            tb_wr    = 1'b1;
            tb_waddr = 4'(p);
            tb_wdata = vals[p];
            @(posedge clk); #1;
        end
        tb_wr = 1'b0;
    endtask

    task automatic fill_sentinel();
        for (int p = 0; p < MEM_D; p++) vals[p] = DATA_W'(16'hA500 + p);
    endtask

    // Reference: ascending sort of vals[0..nn-1] by rank, swaps = inversion count,
    // compares = nn(nn-1)/2, cycles from the 7/9-cycle-per-iteration budget.
    task automatic run_sort(input string tag, input int nn, input int extra_at, input int extra_n);
        logic [DATA_W-1:0] exp_mem [MEM_D];
        int s, c, exp_cyc, k, pos, bad;
        int re0, we0, d0, b0, av0, kv0;
        logic seen;
        s = 0;
        for (int p = 0; p < MEM_D; p++) exp_mem[p] = vals[p];
        for (int p = 0; p < nn; p++) begin
            pos = 0;
            for (int q = 0; q < nn; q++) begin
                if (vals[q] < vals[p] || (vals[q] == vals[p] && q < p)) pos++;
                if (q > p && vals[p] > vals[q]) s++;
            end
            exp_mem[pos] = vals[p];
        end
        c       = (nn < 2) ? 0 : nn * (nn - 1) / 2;
        exp_cyc = (nn < 2) ? 3 : 3 + 2 * (nn - 1) + 7 * c + 2 * s;

        lim = nn;
        re0 = re_cnt; we0 = we_cnt; d0 = done_cnt; b0 = both_cnt; av0 = addr_viol; kv0 = k_viol;
        bus.n     = ADDR_W'(nn);
        bus.start = 1'b1;
        k    = 0;
        seen = 1'b0;
        while (k < 3000 && !seen) begin
            @(posedge clk); #1;
            k++;
            bus.start = (k == extra_at);
            if (k == extra_at) bus.n = ADDR_W'(extra_n);
            if (k == 1) chk({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_cycles"}, 64'(k), 64'(exp_cyc));
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
        chk({tag, "_busy_low_after"}, 64'(bus.busy), 64'd0);
        chk({tag, "_re_pulses"}, 64'(re_cnt - re0), 64'(2 * c));
        chk({tag, "_we_pulses"}, 64'(we_cnt - we0), 64'(2 * s));
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_re_we_overlap"}, 64'(both_cnt - b0), 64'd0);
        chk({tag, "_addr_out_of_range"}, 64'(addr_viol - av0), 64'd0);
        chk({tag, "_k_nonzero"}, 64'(k_viol - kv0), 64'd0);
        bad = 0;
        for (int p = 0; p < MEM_D; p++) begin
            if (mem[p] !== exp_mem[p]) begin
                bad++;
                if (bad == 1) chk({tag, "_mem_first_bad"}, 64'(mem[p]), 64'(exp_mem[p]));
            end
        end
        chk({tag, "_mem_bad_count"}, 64'(bad), 64'd0);
        lim = MEM_D;
    endtask

    initial begin
        int nn, found;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.n     = '0;
        tb_wr     = 1'b0;
        tb_waddr  = '0;
        tb_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", all_outs(), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs_zero", all_outs(), 64'd0);

        fill_sentinel(); vals[0] = 16'd5; vals[1] = 16'd3;
        load_mem();
        run_sort("n2_swap", 2, 0, 0);

        fill_sentinel(); vals[0] = 16'd4; vals[1] = 16'd3; vals[2] = 16'd2; vals[3] = 16'd1;
        load_mem();
        run_sort("n4_reverse", 4, 0, 0);

        fill_sentinel();
        load_mem();
        run_sort("n1", 1, 0, 0);
        run_sort("n0", 0, 0, 0);

        fill_sentinel(); vals[0] = 16'd1; vals[1] = 16'd2; vals[2] = 16'd3;
        load_mem();
        run_sort("n3_sorted", 3, 0, 0);

        // reset in the middle of a write pair
        fill_sentinel(); vals[0] = 16'd4; vals[1] = 16'd3; vals[2] = 16'd2; vals[3] = 16'd1;
        load_mem();
        bus.n = ADDR_W'(4);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 0;
        for (int t = 0; t < 200 && found == 0; t++) begin
            if (bus.mem_we) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rst_wr_j_reached", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_outputs_zero", all_outs(), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_still_idle", 64'(bus.busy), 64'd0);
        fill_sentinel(); vals[0] = 16'd9; vals[1] = 16'hFFFF; vals[2] = 16'd0; vals[3] = 16'd7;
        load_mem();
        run_sort("after_rst", 4, 0, 0);
        chk("after_rst_mem2", 64'(mem[2]), 64'd9);
        chk("after_rst_mem3", 64'(mem[3]), 64'hFFFF);

        // second start mid-sort with a larger n must be ignored
        fill_sentinel(); vals[0] = 16'd30; vals[1] = 16'd20; vals[2] = 16'd10; vals[3] = 16'd1; vals[4] = 16'd0;
        load_mem();
        run_sort("start_while_busy", 3, 6, 5);

        for (int r = 0; r < 8; r++) begin
            nn = int'($urandom_range(0, 8));
            for (int p = 0; p < MEM_D; p++) begin
                if (p >= nn) vals[p] = DATA_W'(16'hA500 + p);
                else if (r[0]) vals[p] = DATA_W'($urandom_range(0, 5));
                else vals[p] = DATA_W'($urandom);
            end
            load_mem();
            run_sort($sformatf("rand%0d_n%0d", r, nn), nn, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
